// File: rtl/rob_id_alloc_scheduler_if.sv
// Requester/free-source and allocator-side signals of the ROB ID scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface rob_id_alloc_scheduler_if #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_REQ  = 2
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          alloc_valid;
    logic [NUM_REQ*ID_WIDTH-1:0] alloc_orig_id;
    logic [NUM_REQ-1:0]          alloc_ready;
    logic [ID_WIDTH-1:0]         alloc_uid;

    logic [NUM_REQ-1:0]          free_valid;
    logic [NUM_REQ*ID_WIDTH-1:0] free_uid;
    logic [NUM_REQ-1:0]          free_ready;

    logic                        restored_valid;
    logic [ID_WIDTH-1:0]         restored_id;
    logic [SRC_W-1:0]            restored_src;

    logic                        al_alloc_req;
    logic [ID_WIDTH-1:0]         al_in_orig_id;
    logic                        al_alloc_gnt;
    logic [ID_WIDTH-1:0]         al_unique_id;
    logic                        al_full;
    logic                        al_free_req;
    logic [ID_WIDTH-1:0]         al_unique_id_to_free;
    logic [ID_WIDTH-1:0]         al_restored_id;

    modport slave (
        input  alloc_valid, alloc_orig_id,
        input  free_valid, free_uid,
        input  al_alloc_gnt, al_unique_id, al_full, al_restored_id,
        output alloc_ready, alloc_uid, free_ready,
        output restored_valid, restored_id, restored_src,
        output al_alloc_req, al_in_orig_id,
        output al_free_req, al_unique_id_to_free
    );

    modport master (
        output alloc_valid, alloc_orig_id,
        output free_valid, free_uid,
        output al_alloc_gnt, al_unique_id, al_full, al_restored_id,
        input  alloc_ready, alloc_uid, free_ready,
        input  restored_valid, restored_id, restored_src,
        input  al_alloc_req, al_in_orig_id,
        input  al_free_req, al_unique_id_to_free
    );
endinterface

// File: rtl/rob_id_alloc_scheduler.sv
// Shares one ROB ID allocator between NUM_REQ alloc requesters and NUM_REQ
// free sources: round-robin allocs, FIFO-buffered frees, quiesce/drain FSM.
module rob_id_alloc_scheduler #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int NUM_REQ         = 2,
    parameter int FREE_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    rob_id_alloc_scheduler_if.slave              bus,
    input  logic                                 quiesce_req_i,
    output logic                                 quiesce_ack_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_underflow_o
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (FREE_FIFO_DEPTH > 1) ? $clog2(FREE_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FREE_FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FREE_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_QUIESCED
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [SRC_W-1:0]   free_ptr_q, free_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               err_q, err_d;
    logic               restored_valid_q;
    logic [ID_WIDTH-1:0] restored_id_q;
    logic [SRC_W-1:0]   restored_src_q;

    logic [ID_WIDTH-1:0] fifo_uid_q [FREE_FIFO_DEPTH];
    logic [SRC_W-1:0]    fifo_src_q [FREE_FIFO_DEPTH];

    logic [SRC_W-1:0]    alloc_sel;
    logic [SRC_W-1:0]    free_sel;
    logic [ID_WIDTH-1:0] push_uid;
    logic [ID_WIDTH-1:0] head_uid;
    logic [SRC_W-1:0]    head_src;
    logic                alloc_pend;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                issue_free;
    logic                issue_alloc;
    logic                grant;

    // Allocator capacity is tracked by the allocator itself; a full
    // allocator just refuses the issue, so al_full never gates anything.
    logic unused_al_full;
    assign unused_al_full = bus.al_full;

    // First requester at or after ptr in rotating order.
    function automatic logic [SRC_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SRC_W-1:0]   ptr
    );
        logic [SRC_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) pick = SRC_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    assign alloc_sel  = rr_pick(bus.alloc_valid, alloc_ptr_q);
    assign free_sel   = rr_pick(bus.free_valid, free_ptr_q);
    assign push_uid   = bus.free_uid[int'(free_sel)*ID_WIDTH +: ID_WIDTH];
    assign head_uid   = fifo_uid_q[rd_ptr_q];
    assign head_src   = fifo_src_q[rd_ptr_q];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign alloc_pend = !rst && (state_q == ST_RUN) && (|bus.alloc_valid);
    assign push       = !rst && !fifo_full && (|bus.free_valid);

    // One allocator slot per cycle: frees win until they have starved a
    // pending alloc STARVE_LIMIT times in a row.
    assign issue_free  = !rst && !fifo_empty &&
                         (!alloc_pend || (starve_q < STARVE_MAX));
    assign issue_alloc = !issue_free && alloc_pend;
    assign grant       = issue_alloc && bus.al_alloc_gnt;

    assign bus.al_alloc_req  = issue_alloc;
    assign bus.al_in_orig_id = issue_alloc ?
        bus.alloc_orig_id[int'(alloc_sel)*ID_WIDTH +: ID_WIDTH] : '0;
    assign bus.alloc_ready   = grant ? (NUM_REQ'(1) << alloc_sel) : '0;
    assign bus.alloc_uid     = grant ? bus.al_unique_id : '0;
    assign bus.free_ready    = push ? (NUM_REQ'(1) << free_sel) : '0;

    assign bus.al_free_req          = issue_free;
    assign bus.al_unique_id_to_free = issue_free ? head_uid : '0;

    assign bus.restored_valid = restored_valid_q;
    assign bus.restored_id    = restored_id_q;
    assign bus.restored_src   = restored_src_q;

    assign quiesce_ack_o   = (state_q == ST_QUIESCED);
    assign outstanding_o   = outstanding_q;
    assign err_underflow_o = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (quiesce_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!quiesce_req_i) begin
                    state_d = ST_RUN;
                end else if (fifo_empty && (outstanding_q == '0)) begin
                    state_d = ST_QUIESCED;
                end
            end
            ST_QUIESCED: begin
                if (!quiesce_req_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        alloc_ptr_d   = alloc_ptr_q;
        free_ptr_d    = free_ptr_q;
        starve_d      = starve_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (issue_alloc) alloc_ptr_d = ptr_inc(alloc_sel);
        if (push) free_ptr_d = ptr_inc(free_sel);

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(issue_free);
        count_d  = count_q + CNT_W'(push) - CNT_W'(issue_free);

        if (!alloc_pend || issue_alloc) begin
            starve_d = '0;
        end else if (issue_free && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        // Grant and free issue share the slot, so they never coincide.
        if (grant) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (issue_free) begin
            if (outstanding_q == '0) err_d = 1'b1;
            else outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            alloc_ptr_q      <= '0;
            free_ptr_q       <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            starve_q         <= '0;
            outstanding_q    <= '0;
            err_q            <= 1'b0;
            restored_valid_q <= 1'b0;
            restored_id_q    <= '0;
            restored_src_q   <= '0;
        end else begin
            state_q          <= state_d;
            alloc_ptr_q      <= alloc_ptr_d;
            free_ptr_q       <= free_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            starve_q         <= starve_d;
            outstanding_q    <= outstanding_d;
            err_q            <= err_d;
            restored_valid_q <= issue_free;
            if (issue_free) begin
                restored_id_q  <= bus.al_restored_id;
                restored_src_q <= head_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_uid_q[wr_ptr_q] <= push_uid;
            fifo_src_q[wr_ptr_q] <= free_sel;
        end
    end
endmodule
